// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: free-running counters, combinational coordinate
// decode, and a one-cycle registered sync/colour output stage. Optional VGA_SYNC_PATTERN_EN.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] rgb_i,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output logic        active_o,
  output logic        frame_start_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] rgb_o
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic POL    = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic        hs_act;
  logic        vs_act;
  logic [11:0] pix_rgb;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == 10'(H_TOT - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 10'd1;
    end else begin
      hcnt <= hcnt + 10'd1;
    end
  end

  // Stage 0: the pixel source sees these in the same cycle it must supply rgb_i.
  assign x_o           = hcnt;
  assign y_o           = vcnt;
  assign active_o      = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
  assign frame_start_o = (hcnt == '0) && (vcnt == '0) && !rst_i;

  assign hs_act = (hcnt >= 10'(HS_START)) && (hcnt < 10'(HS_END));
  assign vs_act = (vcnt >= 10'(VS_START)) && (vcnt < 10'(VS_END));

`ifdef VGA_SYNC_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  // Eight equal-width colour bars across the visible line; rgb_i is ignored.
  always_comb begin
    pix_rgb = 12'h000;
    if      (hcnt < 10'(BAR_W))     pix_rgb = 12'hFFF;
    else if (hcnt < 10'(2 * BAR_W)) pix_rgb = 12'hFF0;
    else if (hcnt < 10'(3 * BAR_W)) pix_rgb = 12'h0FF;
    else if (hcnt < 10'(4 * BAR_W)) pix_rgb = 12'h0F0;
    else if (hcnt < 10'(5 * BAR_W)) pix_rgb = 12'hF0F;
    else if (hcnt < 10'(6 * BAR_W)) pix_rgb = 12'hF00;
    else if (hcnt < 10'(7 * BAR_W)) pix_rgb = 12'h00F;
    else                            pix_rgb = 12'h000;
  end
`else
  assign pix_rgb = rgb_i;
`endif

  // Stage 1: syncs and colour share one register stage so they stay aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsync_o <= ~POL;
      vsync_o <= ~POL;
      rgb_o   <= 12'h000;
    end else begin
      hsync_o <= hs_act ? POL : ~POL;
      vsync_o <= vs_act ? POL : ~POL;
      rgb_o   <= active_o ? pix_rgb : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance plus a shrunken active-high-sync instance
// (so whole frames fit in a short run), both checked every cycle against a position model.
module tb_vga_sync_gen;

  localparam int M_HA = 640, M_HF = 16, M_HS = 96, M_HB = 48;
  localparam int M_VA = 480, M_VF = 10, M_VS = 2,  M_VB = 33;
  localparam int M_HT = M_HA + M_HF + M_HS + M_HB;
  localparam int M_VT = M_VA + M_VF + M_VS + M_VB;
  localparam int S_HA = 16, S_HF = 2, S_HS = 4, S_HB = 3;
  localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic        clk;
  logic        rst_i;
  logic [11:0] rgb_m, rgb_s;
  logic [9:0]  x_m, y_m, x_s, y_s;
  logic        act_m, fs_m, hs_m, vs_m, act_s, fs_s, hs_s, vs_s;
  logic [11:0] rgbo_m, rgbo_s;

  vga_sync_gen u_dut (
    .clk_i(clk), .rst_i(rst_i), .rgb_i(rgb_m), .x_o(x_m), .y_o(y_m),
    .active_o(act_m), .frame_start_o(fs_m), .hsync_o(hs_m), .vsync_o(vs_m), .rgb_o(rgbo_m)
  );

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB), .SYNC_POL(1)
  ) u_dut_small (
    .clk_i(clk), .rst_i(rst_i), .rgb_i(rgb_s), .x_o(x_s), .y_o(y_s),
    .active_o(act_s), .frame_start_o(fs_s), .hsync_o(hs_s), .vsync_o(vs_s), .rgb_o(rgbo_s)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int t;
  bit pat_mode;
  logic [13:0] exp_q_m[$];
  logic [13:0] exp_q_s[$];

  logic prev_hs_m, prev_vs_s;
  int   hs_fall_t, vs_rise_t, fs_t;
  bit   hs_fall_v, vs_rise_v, fs_v;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected colour for a position, derived from the visible-area and bar rules.
  function automatic logic [11:0] exp_col(int x, int y, int ha, int va, logic [11:0] in);
    if (x >= ha || y >= va) return 12'h000;
`ifdef VGA_SYNC_PATTERN_EN
    case (x / (ha / 8))
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return in;
`endif
  endfunction

  function automatic logic sync_lvl(bit on, logic pol);
    return on ? pol : ~pol;
  endfunction

  // One clock: advance the model, compare both instances, drive next rgb, queue expectations.
  task automatic step();
    logic [13:0] er_m, er_s;
    logic [11:0] c;
    int mx, my, sx, sy;
    bit hon, von;
    @(posedge clk);
    #1;
    if (rst_i) begin
      t = 0;
      exp_q_m.delete();
      exp_q_s.delete();
      er_m = {1'b1, 1'b1, 12'h000};
      er_s = {1'b0, 1'b0, 12'h000};
      hs_fall_v = 0;
      vs_rise_v = 0;
      fs_v = 0;
    end else begin
      t++;
      er_m = (exp_q_m.size() > 0) ? exp_q_m.pop_front() : 14'h3000;
      er_s = (exp_q_s.size() > 0) ? exp_q_s.pop_front() : 14'h0000;
    end
    mx = t % M_HT;
    my = (t / M_HT) % M_VT;
    sx = t % S_HT;
    sy = (t / S_HT) % S_VT;

    check_eq("m_cycle", {x_m, y_m, act_m, fs_m, hs_m, vs_m, rgbo_m},
             {10'(mx), 10'(my), (mx < M_HA) && (my < M_VA), (mx == 0) && (my == 0) && !rst_i, er_m});
    check_eq("s_cycle", {x_s, y_s, act_s, fs_s, hs_s, vs_s, rgbo_s},
             {10'(sx), 10'(sy), (sx < S_HA) && (sy < S_VA), (sx == 0) && (sy == 0) && !rst_i, er_s});

    if (!rst_i) begin
      if (prev_hs_m && !hs_m) begin
        check_eq("m_hs_start", 64'(t % 800), 64'd657);
        if (hs_fall_v) check_eq("m_hs_period", 64'(t - hs_fall_t), 64'd800);
        hs_fall_t = t;
        hs_fall_v = 1;
      end
      if (!prev_hs_m && hs_m && hs_fall_v) check_eq("m_hs_width", 64'(t - hs_fall_t), 64'd96);
      if (!prev_vs_s && vs_s) begin
        check_eq("s_vs_start", 64'(t % (S_HT * S_VT)), 64'((S_VA + S_VF) * S_HT + 1));
        vs_rise_t = t;
        vs_rise_v = 1;
      end
      if (prev_vs_s && !vs_s && vs_rise_v) check_eq("s_vs_width", 64'(t - vs_rise_t), 64'(S_VS * S_HT));
      if (fs_s) begin
        if (fs_v) check_eq("s_frame_period", 64'(t - fs_t), 64'(S_HT * S_VT));
        fs_t = t;
        fs_v = 1;
      end
    end
    prev_hs_m = hs_m;
    prev_vs_s = vs_s;

    // driver: colour for the current coordinate
    if (pat_mode) begin
      c = {4'(mx), 4'(my), 4'hA};
      rgb_m = c;
    end else begin
      rgb_m = 12'($urandom);
    end
    rgb_s = 12'($urandom);
    hon = (mx >= M_HA + M_HF) && (mx < M_HA + M_HF + M_HS);
    von = (my >= M_VA + M_VF) && (my < M_VA + M_VF + M_VS);
    exp_q_m.push_back({sync_lvl(hon, 1'b0), sync_lvl(von, 1'b0), exp_col(mx, my, M_HA, M_VA, rgb_m)});
    hon = (sx >= S_HA + S_HF) && (sx < S_HA + S_HF + S_HS);
    von = (sy >= S_VA + S_VF) && (sy < S_VA + S_VF + S_VS);
    exp_q_s.push_back({sync_lvl(hon, 1'b1), sync_lvl(von, 1'b1), exp_col(sx, sy, S_HA, S_VA, rgb_s)});
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_m_xy"}, {x_m, y_m}, 20'h0);
    check_eq({tag, "_m_sync"}, {hs_m, vs_m}, 2'b11);
    check_eq({tag, "_m_rgb"}, rgbo_m, 12'h000);
    check_eq({tag, "_m_act_fs"}, {act_m, fs_m}, 2'b10);
    check_eq({tag, "_s_sync"}, {hs_s, vs_s}, 2'b00);
  endtask

  initial begin
    rst_i = 1'b1;
    rgb_m = '0;
    rgb_s = '0;
    t = 0;
    pat_mode = 1;
    prev_hs_m = 1'b1;
    prev_vs_s = 1'b0;
    hs_fall_t = 0; vs_rise_t = 0; fs_t = 0;
    hs_fall_v = 0; vs_rise_v = 0; fs_v = 0;

    repeat (5) step();
    check_reset_state("rst");
    rst_i = 1'b0;
    #1;
    check_eq("first_fs_m", fs_m, 1'b1);
    check_eq("first_fs_s", fs_s, 1'b1);

    // Alignment/blanking with the coordinate-derived colour, then random colour.
    repeat (8000) step();
    pat_mode = 0;
    repeat (8300) step();

    // One-cycle reset at (300,20) of the full-size frame.
    check_eq("pre_rst_pos", {x_m, y_m}, {10'd300, 10'd20});
    rst_i = 1'b1;
    step();
    check_reset_state("midrst");
    rst_i = 1'b0;
    #1;
    check_eq("midrst_fs_m", fs_m, 1'b1);
    pat_mode = 1;
    repeat (6000) step();

    // Reset of random length at a random point.
    pat_mode = 0;
    repeat ($urandom_range(1, 900)) step();
    rst_i = 1'b1;
    repeat ($urandom_range(1, 3)) step();
    check_reset_state("rndrst");
    rst_i = 1'b0;
    repeat (4000) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
